// File: rtl/prog_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_ctrl_pkg
// Description : Shared types, state codes, program base table and ProgSel
//               wrap helper for the program run controller.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_ctrl_pkg;

  // Controller state codes (legacy-compatible constant form)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    LOAD  = ST_LOAD,
    RUN   = ST_RUN,
    DONE  = ST_DONE,
    FAULT = ST_FAULT
  } run_state_t;

  // Base address of each program; entry 0 is the "no program yet" value
  localparam logic [9:0] PROG_BASE [0:3] = '{10'd0, 10'd0, 10'd200, 10'd400};

  // Round-robin program selection: 0->1, 1->2, 2->3, 3->1
  function automatic logic [1:0] next_prog(input logic [1:0] cur);
    return (cur == 2'd3) ? 2'd1 : cur + 2'd1;
  endfunction

endpackage : prog_ctrl_pkg
`default_nettype wire

// File: rtl/prog_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_run_ctrl_if
// Description : Harness/PC-side signal bundle of the program run controller.
//               master = harness and decoder side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_run_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
);
  logic             Start;
  logic             Halt;
  logic             Stall;
  logic             PcLoad;
  logic [PC_W-1:0]  PcLoadAddr;
  logic             PcEn;
  logic [1:0]       ProgSel;
  logic             Running;
  logic             Done;
  logic             Fault;
  logic [CYC_W-1:0] CycleCount;

  modport master (
    output Start, Halt, Stall,
    input  PcLoad, PcLoadAddr, PcEn, ProgSel, Running, Done, Fault, CycleCount
  );

  modport slave (
    input  Start, Halt, Stall,
    output PcLoad, PcLoadAddr, PcEn, ProgSel, Running, Done, Fault, CycleCount
  );
endinterface : prog_run_ctrl_if
`default_nettype wire

// File: rtl/prog_run_ctrl_run_cycle_ctr.sv
`default_nettype none
// ============================================================================
// Module      : run_cycle_ctr
// Description : Saturating RUN-cycle counter with synchronous clear, count
//               enable and a terminal-count flag at MAX_CYCLES-1.
// Revision    : 1.0 - initial release
// ============================================================================
module run_cycle_ctr #(
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd60000
) (
  input  wire logic             Clk,
  input  wire logic             Reset,
  input  wire logic             clr_i,
  input  wire logic             en_i,
  output logic      [CYC_W-1:0] count_o,
  output logic                  tc_o
);

  localparam logic [CYC_W-1:0] TC_VAL = MAX_CYCLES - CYC_W'(1);

  logic [CYC_W-1:0] count_q;
  logic [CYC_W-1:0] count_d;

  // Clear wins over enable; increment holds at all-ones
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + CYC_W'(1);
    end
  end

  // Count register, cleared asynchronously by reset
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TC_VAL);

endmodule : run_cycle_ctr
`default_nettype wire

// File: rtl/prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_run_ctrl
// Description : Run controller sequencing the program counter: turns the
//               Start strobe into PC load/enable, picks programs 1-2-3
//               round-robin, stops on Halt or watchdog, reports status.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_run_ctrl
  import prog_ctrl_pkg::*;
#(
  parameter int               PC_W       = 10,
  parameter int               CYC_W      = 16,
  parameter logic [CYC_W-1:0] MAX_CYCLES = 16'd60000
) (
  input  wire logic      Clk,
  input  wire logic      Reset,
  prog_run_ctrl_if.slave bus
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [1:0]       prog_q;
  logic [1:0]       prog_d;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic [CYC_W-1:0] cnt_val;

  run_cycle_ctr #(
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_ctr (
    .Clk     (Clk),
    .Reset   (Reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt_val),
    .tc_o    (cnt_tc)
  );

  // Next-state, program advance and counter control; Start beats Halt beats watchdog
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (bus.Start) begin
          state_d = ST_LOAD;
          prog_d  = next_prog(prog_q);
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!bus.Start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.Start) begin
          state_d = ST_LOAD;
          prog_d  = next_prog(prog_q);
          cnt_clr = 1'b1;
        end else if (bus.Halt) begin
          // The halt cycle itself is counted
          state_d = ST_DONE;
          cnt_en  = 1'b1;
        end else if (cnt_tc) begin
          // Count stops at MAX_CYCLES-1 instead of reaching MAX_CYCLES
          state_d = ST_FAULT;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and program-select registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      prog_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
    end
  end

  // Moore output decode; PcEn additionally gated by the live Stall input
  assign bus.PcLoad     = (state_q == ST_LOAD);
  assign bus.PcEn       = (state_q == ST_RUN) && !bus.Stall;
  assign bus.PcLoadAddr = PC_W'(PROG_BASE[prog_q]);
  assign bus.ProgSel    = prog_q;
  assign bus.Running    = (state_q == ST_RUN);
  assign bus.Done       = (state_q == ST_DONE);
  assign bus.Fault      = (state_q == ST_FAULT);
  assign bus.CycleCount = cnt_val;

endmodule : prog_run_ctrl
`default_nettype wire

// File: tb/tb_prog_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_run_ctrl
// Description : Self-checking bench: two controllers (default watchdog and
//               MAX_CYCLES=20) share directed stimulus and are compared each
//               cycle against a behavioural model, plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_run_ctrl;

  logic clk;
  logic rst_n;
  logic start_r;
  logic halt_r;
  logic stall_r;

  int n_chk = 0;
  int n_err = 0;

  prog_run_ctrl_if #(.PC_W(10), .CYC_W(16)) bus0 ();
  prog_run_ctrl_if #(.PC_W(10), .CYC_W(16)) bus1 ();

  assign bus0.Start = start_r;
  assign bus0.Halt  = halt_r;
  assign bus0.Stall = stall_r;
  assign bus1.Start = start_r;
  assign bus1.Halt  = halt_r;
  assign bus1.Stall = stall_r;

  prog_run_ctrl dut0 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus0)
  );

  prog_run_ctrl #(.MAX_CYCLES(16'd20)) dut1 (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 running, 3 done, 4 fault
  int m_mode [2];
  int m_prog [2];
  int m_cnt  [2];
  int m_max  [2] = '{60000, 20};
  int base_tbl [4] = '{0, 0, 200, 400};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_mode[i] <= 0;
        m_prog[i] <= 0;
        m_cnt[i]  <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_mode[i] == 1) begin
          if (!start_r) m_mode[i] <= 2;
        end else if (m_mode[i] == 2) begin
          if (start_r) begin
            m_mode[i] <= 1;
            m_prog[i] <= (m_prog[i] % 3) + 1;
            m_cnt[i]  <= 0;
          end else if (halt_r) begin
            m_mode[i] <= 3;
            m_cnt[i]  <= (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
          end else if (m_cnt[i] + 1 >= m_max[i]) begin
            m_mode[i] <= 4;
          end else begin
            m_cnt[i]  <= (m_cnt[i] >= 65535) ? 65535 : m_cnt[i] + 1;
          end
        end else if (start_r) begin
          m_mode[i] <= 1;
          m_prog[i] <= (m_prog[i] % 3) + 1;
          m_cnt[i]  <= 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cmp_inst(input int i, input string tag,
                          input logic pcload, input logic [9:0] addr,
                          input logic pcen, input logic [1:0] sel,
                          input logic run, input logic done, input logic fault,
                          input logic [15:0] cnt);
    chk({tag, ".PcLoad"},     32'(pcload), 32'(m_mode[i] == 1));
    chk({tag, ".PcLoadAddr"}, 32'(addr),   32'(base_tbl[m_prog[i]]));
    chk({tag, ".PcEn"},       32'(pcen),   32'((m_mode[i] == 2) && !stall_r));
    chk({tag, ".ProgSel"},    32'(sel),    32'(m_prog[i]));
    chk({tag, ".Running"},    32'(run),    32'(m_mode[i] == 2));
    chk({tag, ".Done"},       32'(done),   32'(m_mode[i] == 3));
    chk({tag, ".Fault"},      32'(fault),  32'(m_mode[i] == 4));
    chk({tag, ".CycleCount"}, 32'(cnt),    32'(m_cnt[i]));
  endtask

  // Every-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    cmp_inst(0, "dut0", bus0.PcLoad, bus0.PcLoadAddr, bus0.PcEn, bus0.ProgSel,
             bus0.Running, bus0.Done, bus0.Fault, bus0.CycleCount);
    cmp_inst(1, "dut1", bus1.PcLoad, bus1.PcLoadAddr, bus1.PcEn, bus1.ProgSel,
             bus1.Running, bus1.Done, bus1.Fault, bus1.CycleCount);
  end

  // Drive inputs for the current cycle, then move past the next active edge
  task automatic tick(input logic s, input logic h, input logic st);
    start_r = s;
    halt_r  = h;
    stall_r = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    start_r = 1'b0;
    halt_r  = 1'b0;
    stall_r = 1'b0;
    @(posedge clk);
    #1;
    tick(0, 0, 0);
    chk("lit.reset.Running", 32'(bus0.Running), 32'd0);
    chk("lit.reset.ProgSel", 32'(bus0.ProgSel), 32'd0);
    rst_n = 1'b1;
    tick(0, 1, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("lit.idle.Done", 32'(bus0.Done), 32'd0);

    // Run 1: single-cycle Start, halt after 12 RUN cycles
    tick(1, 0, 0);
    chk("lit.load1.PcLoad",     32'(bus0.PcLoad),     32'd1);
    chk("lit.load1.ProgSel",    32'(bus0.ProgSel),    32'd1);
    chk("lit.load1.PcLoadAddr", 32'(bus0.PcLoadAddr), 32'd0);
    tick(0, 0, 0);
    chk("lit.run1.Running", 32'(bus0.Running), 32'd1);
    chk("lit.run1.PcEn",    32'(bus0.PcEn),    32'd1);
    chk("lit.run1.PcLoad",  32'(bus0.PcLoad),  32'd0);
    for (int k = 0; k < 11; k++) tick(0, 0, 0);
    tick(0, 1, 0);
    chk("lit.done1.Done",       32'(bus0.Done),       32'd1);
    chk("lit.done1.CycleCount", 32'(bus0.CycleCount), 32'd12);
    chk("lit.done1.PcEn",       32'(bus0.PcEn),       32'd0);
    tick(0, 0, 0);
    tick(0, 0, 0);

    // Runs 2 and 3: round-robin program selection
    tick(1, 0, 0);
    chk("lit.load2.ProgSel",    32'(bus0.ProgSel),    32'd2);
    chk("lit.load2.PcLoadAddr", 32'(bus0.PcLoadAddr), 32'd200);
    tick(0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 0);
    tick(0, 1, 0);
    tick(1, 0, 0);
    chk("lit.load3.ProgSel",    32'(bus0.ProgSel),    32'd3);
    chk("lit.load3.PcLoadAddr", 32'(bus0.PcLoadAddr), 32'd400);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 0);

    // Run 4: Start held 5 cycles, wraps to program 1, then 3 stalled cycles
    for (int k = 0; k < 5; k++) tick(1, 0, 0);
    chk("lit.load4.PcLoad",     32'(bus0.PcLoad),     32'd1);
    chk("lit.load4.ProgSel",    32'(bus0.ProgSel),    32'd1);
    chk("lit.load4.PcLoadAddr", 32'(bus0.PcLoadAddr), 32'd0);
    tick(0, 0, 0);
    for (int k = 0; k < 3; k++) tick(0, 0, 1);
    chk("lit.stall.PcEn",       32'(bus0.PcEn),       32'd0);
    chk("lit.stall.CycleCount", 32'(bus0.CycleCount), 32'd3);
    tick(0, 0, 0);
    chk("lit.unstall.PcEn", 32'(bus0.PcEn), 32'd1);

    // Watchdog on the MAX_CYCLES=20 instance
    for (int k = 0; k < 20; k++) tick(0, 0, 0);
    chk("lit.wd.dut1.Fault",      32'(bus1.Fault),      32'd1);
    chk("lit.wd.dut1.CycleCount", 32'(bus1.CycleCount), 32'd19);
    chk("lit.wd.dut1.PcEn",       32'(bus1.PcEn),       32'd0);
    chk("lit.wd.dut0.CycleCount", 32'(bus0.CycleCount), 32'd24);

    // Start and Halt together: abort wins; Fault clears on new Start
    tick(1, 1, 0);
    chk("lit.abort.PcLoad",  32'(bus0.PcLoad),  32'd1);
    chk("lit.abort.ProgSel", 32'(bus0.ProgSel), 32'd2);
    chk("lit.abort.Done",    32'(bus0.Done),    32'd0);
    chk("lit.abort.dut1.Fault", 32'(bus1.Fault), 32'd0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 0, 0);
    tick(0, 1, 1);
    chk("lit.haltstall.Done", 32'(bus0.Done), 32'd1);

    // Mid-run reset at count 37
    tick(1, 0, 0);
    tick(0, 0, 0);
    for (int k = 0; k < 37; k++) tick(0, 0, 0);
    chk("lit.prereset.CycleCount", 32'(bus0.CycleCount), 32'd37);
    rst_n = 1'b0;
    #1;
    chk("lit.rst.Running",    32'(bus0.Running),    32'd0);
    chk("lit.rst.ProgSel",    32'(bus0.ProgSel),    32'd0);
    chk("lit.rst.CycleCount", 32'(bus0.CycleCount), 32'd0);
    chk("lit.rst.PcLoadAddr", 32'(bus0.PcLoadAddr), 32'd0);
    @(posedge clk);
    #1;
    tick(0, 0, 0);
    rst_n = 1'b1;
    tick(0, 1, 1);
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("lit.postrst.Running", 32'(bus0.Running), 32'd0);
    chk("lit.postrst.PcLoad",  32'(bus0.PcLoad),  32'd0);
    chk("lit.postrst.Fault",   32'(bus1.Fault),   32'd0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule : tb_prog_run_ctrl
`default_nettype wire
